// File: rtl/stream_demux_n.sv
// Registered 1-to-N_CH stream demultiplexer with packet-locked channel selection.
// Optional STREAM_DEMUX_DROP_EN: invalid selects are discarded and counted on drop_cnt.
module stream_demux_n #(
    parameter  int W     = 8,
    parameter  int N_CH  = 4,
    localparam int SEL_W = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        in_data,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic [SEL_W-1:0]    in_sel,
    output logic                in_ready,
    output logic [N_CH*W-1:0]   out_data,
    output logic [N_CH-1:0]     out_valid,
    output logic [N_CH-1:0]     out_last,
    input  logic [N_CH-1:0]     out_ready
`ifdef STREAM_DEMUX_DROP_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    localparam logic [SEL_W:0]   LP_NCH     = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] LP_LAST_CH = SEL_W'(N_CH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_lock_ch;
    logic [SEL_W-1:0] r_hch;
    logic [W-1:0]     r_hdata;
    logic             r_hlast;
    logic             r_full;
    logic [SEL_W-1:0] w_ch;
    logic [N_CH-1:0]  w_hsel;
    logic             w_hready;
    logic             w_sel_bad;
    logic             w_drop;
    logic             w_accept;

    assign w_sel_bad = {1'b0, in_sel} >= LP_NCH;

`ifdef STREAM_DEMUX_DROP_EN
    logic        r_lock_drop;
    logic [15:0] r_drop_cnt;

    // A packet whose first beat had a bad select stays "dropping" until its last beat
    assign w_drop   = (r_state == ST_IDLE) ? w_sel_bad : r_lock_drop;
    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_drop <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (r_state == ST_IDLE && w_accept && !in_last) begin
                r_lock_drop <= w_drop;
            end
            if (w_accept && w_drop && r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end
`else
    assign w_drop = 1'b0;
`endif

    always_comb begin
        w_ch = r_lock_ch;
        if (r_state == ST_IDLE) begin
            w_ch = w_sel_bad ? LP_LAST_CH : in_sel;
        end
    end

    always_comb begin
        w_hsel = '0;
        for (int unsigned k = 0; k < unsigned'(N_CH); k++) begin
            w_hsel[k] = (r_hch == SEL_W'(k));
        end
    end

    assign w_hready = r_full && |(w_hsel & out_ready);
    assign in_ready = w_drop || !r_full || w_hready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && !in_last) w_state_nxt = ST_LOCK;
            ST_LOCK: if (w_accept && in_last)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_ch <= '0;
        end else if (r_state == ST_IDLE && w_accept && !in_last) begin
            r_lock_ch <= w_ch;
        end
    end

    // Reload on accept takes priority over drain, so full stays set on simultaneous drain+accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_hdata <= '0;
            r_hlast <= 1'b0;
            r_hch   <= '0;
        end else if (w_accept && !w_drop) begin
            r_full  <= 1'b1;
            r_hdata <= in_data;
            r_hlast <= in_last;
            r_hch   <= w_ch;
        end else if (w_hready) begin
            r_full  <= 1'b0;
        end
    end

    always_comb begin
        out_valid = '0;
        out_last  = '0;
        out_data  = '0;
        for (int unsigned k = 0; k < unsigned'(N_CH); k++) begin
            out_valid[k]       = r_full && w_hsel[k];
            out_last[k]        = r_full && w_hsel[k] && r_hlast;
            out_data[k*W +: W] = (r_full && w_hsel[k]) ? r_hdata : '0;
        end
    end

endmodule

// File: tb/tb_stream_demux_n.sv
// Scoreboard bench for stream_demux_n: a 4-channel instance under directed and random
// traffic, plus a 3-channel instance exercising the invalid-select path.
module tb_stream_demux_n;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic [1:0]     in_sel;
    logic           in_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_last;
    logic [N-1:0]   out_ready;

    logic [W-1:0]   in_data3;
    logic           in_valid3;
    logic           in_last3;
    logic [1:0]     in_sel3;
    logic           in_ready3;
    logic [3*W-1:0] out_data3;
    logic [2:0]     out_valid3;
    logic [2:0]     out_last3;
    logic [2:0]     out_ready3;

`ifdef STREAM_DEMUX_DROP_EN
    logic [15:0] drop_cnt;
    logic [15:0] drop_cnt3;
`endif

    stream_demux_n #(.W(W), .N_CH(N)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_sel(in_sel),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready)
`ifdef STREAM_DEMUX_DROP_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    stream_demux_n #(.W(W), .N_CH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_sel(in_sel3),
        .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3),
        .out_ready(out_ready3)
`ifdef STREAM_DEMUX_DROP_EN
        , .drop_cnt(drop_cnt3)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a packet's channel is the select of its first beat; beats leave in order.
    typedef struct {
        int         ch;
        logic [W-1:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    bit    m_in_pkt = 1'b0;
    int    m_ch     = 0;
    bit    rand_ready = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_in_pkt = 1'b0;
        end else if (in_valid && in_ready) begin
            if (!m_in_pkt) m_ch = int'(in_sel);
            exp_q.push_back('{ch: m_ch, data: in_data, last: in_last});
            m_in_pkt = !in_last;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid != '0) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q[0];
                chk("route", 64'(out_valid), 64'd1 << e.ch);
                if (out_ready[e.ch]) begin
                    void'(exp_q.pop_front());
                    chk("data", 64'(out_data), 64'(e.data) << (W * e.ch));
                    chk("last", 64'(out_last), 64'(e.last) << e.ch);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 4'($urandom | $urandom);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] s, input logic l);
        int unsigned waited = 0;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned len;
        int unsigned waited;

        rst = 1'b1;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_sel = '0; out_ready = 4'hF;
        in_data3 = '0; in_valid3 = 1'b0; in_last3 = 1'b0; in_sel3 = '0; out_ready3 = 3'h7;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid3", 64'(out_valid3), 64'd0);
`ifdef STREAM_DEMUX_DROP_EN
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        step();

        // Invalid select on the 3-channel instance, 2-beat packet
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h5A; in_last3 = 1'b0;
        @(negedge clk);
        chk("inv_ready0", 64'(in_ready3), 64'd1);
        step();
        in_data3 = 8'h6B; in_last3 = 1'b1; in_sel3 = 2'd0;
        @(negedge clk);
        chk("inv_ready1", 64'(in_ready3), 64'd1);
`ifdef STREAM_DEMUX_DROP_EN
        chk("inv_drop_valid0", 64'(out_valid3), 64'd0);
        chk("inv_drop_cnt1", 64'(drop_cnt3), 64'd1);
`else
        chk("inv_valid0", 64'(out_valid3), 64'b100);
        chk("inv_data0", 64'(out_data3), 64'h5A0000);
        chk("inv_last0", 64'(out_last3), 64'd0);
`endif
        step();
        in_valid3 = 1'b0;
        @(negedge clk);
`ifdef STREAM_DEMUX_DROP_EN
        chk("inv_drop_valid1", 64'(out_valid3), 64'd0);
        chk("inv_drop_cnt2", 64'(drop_cnt3), 64'd2);
`else
        chk("inv_valid1", 64'(out_valid3), 64'b100);
        chk("inv_data1", 64'(out_data3), 64'h6B0000);
        chk("inv_last1", 64'(out_last3), 64'b100);
`endif
        step();

        // Single beats, one-cycle latency
        send(8'hA5, 2'd2, 1'b1);
        @(negedge clk);
        chk("single_valid_a5", 64'(out_valid), 64'b0100);
        chk("single_data_a5", 64'(out_data), 64'h00A5_0000);
        step();
        send(8'h3C, 2'd0, 1'b1);
        @(negedge clk);
        chk("single_valid_3c", 64'(out_valid), 64'b0001);
        chk("single_data_3c", 64'(out_data), 64'h0000_003C);
        step();

        // Packet lock: later selects ignored
        send(8'h11, 2'd1, 1'b0);
        send(8'h22, 2'd3, 1'b0);
        send(8'h33, 2'd3, 1'b1);
        @(negedge clk);
        chk("lock_valid", 64'(out_valid), 64'b0010);
        chk("lock_data", 64'(out_data), 64'h0000_3300);
        chk("lock_last", 64'(out_last), 64'b0010);
        step();

        // Backpressure on lane 1
        out_ready = 4'b1101;
        send(8'h44, 2'd1, 1'b1);
        in_data = 8'h55; in_sel = 2'd0; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk("bp_hold", 64'(out_data), 64'h0000_4400);
        end
        @(posedge clk);
        #1;
        out_ready = 4'hF;
        @(negedge clk);
        chk("bp_release", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_reload_valid", 64'(out_valid), 64'b0001);
        chk("bp_reload_data", 64'(out_data), 64'h0000_0055);
        step();

        // Reset mid-packet
        send(8'h61, 2'd2, 1'b0);
        send(8'h62, 2'd2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        step();
        send(8'h77, 2'd3, 1'b1);
        @(negedge clk);
        chk("rst_mid_route", 64'(out_valid), 64'b1000);
        chk("rst_mid_data", 64'(out_data), 64'h7700_0000);
        step();

        // Randomized traffic with random per-lane readiness
        rand_ready = 1'b1;
        for (int p = 0; p < 150; p++) begin
            len = $urandom_range(1, 4);
            for (int unsigned b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 1)) step();
                send(W'($urandom), 2'($urandom), b == len - 1);
            end
        end
        rand_ready = 1'b0;
        step();
        step();
        out_ready = 4'hF;
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            waited++;
            step();
        end
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);
`ifdef STREAM_DEMUX_DROP_EN
        chk("main_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Registered 1-to-N stream demultiplexer with valid/ready handshaking, generalising the single-bit 1:2 demux to N_CH channels of W-bit data. One input stream is routed, through a single output holding register, to the channel chosen by `in_sel`; channels not selected are driven to zero. Multi-beat packets keep their channel from first beat through the `in_last` beat. The block sits between a single producer and N downstream consumers in the datapath.

## Interface
- `W`, 8: data width per beat (≥1).
- `N_CH`, 4: number of output channels (2..16).
- `SEL_W`, `$clog2(N_CH)`: select width (localparam, minimum 1).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  W  input beat.
- `in_valid`  in  1  input beat present.
- `in_last`  in  1  final beat of packet.
- `in_sel`  in  SEL_W  destination channel; sampled only on the first beat of a packet.
- `in_ready`  out  1  block accepts the beat this cycle.
- `out_data`  out  N_CH*W  lane k = bits [k*W +: W]; held data on the selected lane, zero on all others.
- `out_valid`  out  N_CH  one-hot or zero.
- `out_last`  out  N_CH  last flag on the selected lane, zero elsewhere.
- `out_ready`  in  N_CH  per-channel consumer ready.
- `drop_cnt`  out  16  present only with `STREAM_DEMUX_DROP_EN`.

One clock, `clk`; reset `rst` is synchronous and active-high.

## Operation
- Input handshake: beat accepted when `in_valid && in_ready`. Output handshake on lane k: `out_valid[k] && out_ready[k]`.
- Holding register: `full`, `hdata`, `hlast`, `hch`. `in_ready = !full || out_ready[hch]`, so pass-through rate is 1 beat/cycle.
- Channel resolution on an accepted beat: in IDLE, `ch = in_sel`; in LOCK, `ch = lock_ch`.
- FSM:
  - IDLE: an accepted beat with `in_last=0` records `lock_ch = ch` and moves to LOCK. An accepted beat with `in_last=1` stays in IDLE.
  - LOCK: `in_sel` is ignored. An accepted beat with `in_last=1` moves to IDLE.
- `out_valid[k] = full && (hch == k)`. `out_data` lane k is `hdata` when `out_valid[k]`, else 0. `out_last` follows the same rule.
- Invalid select (`in_sel >= N_CH`, only possible when N_CH is not a power of 2): behaviour is set by the Configuration section.
- Simultaneous drain and accept in the same cycle: the register reloads with the new beat; `full` stays 1.
- `out_ready` on non-selected lanes is ignored.

## Timing
- Latency: a beat accepted at edge n is visible on the outputs after edge n; it is consumed at the first edge where `out_ready[hch]=1`.
- Reset values: `full=0`, `out_valid=0`, `out_data=0`, `out_last=0`, FSM=IDLE, `lock_ch=0`, `drop_cnt=0`; `in_ready` is 1 on the cycle after reset.
- Reset mid-packet: the held beat is discarded and the FSM returns to IDLE. The next beat is treated as a first beat.
- `in_ready` is combinational from `out_ready` and registered state only, never from `in_valid`.
- Backpressure: while `full` and `!out_ready[hch]`, `in_ready=0` and the holding register is stable.

## Configuration
- Macro: `STREAM_DEMUX_DROP_EN`.
- Defined:
  - A first beat with invalid `in_sel` is accepted (`in_ready=1` regardless of `full`) and discarded, and so are the remaining beats of that packet (lock target "drop").
  - `drop_cnt` increments by 1 per discarded beat and saturates at 16'hFFFF.
  - Discarded beats never set `full`.
- Not defined:
  - Invalid `in_sel` is routed to channel N_CH-1.
  - The `drop_cnt` port is absent.

## Test plan
- Reset then single beats: W=8, N_CH=4, `out_ready=4'hF`; beats 0xA5 sel 2 and 0x3C sel 0, `in_last=1` each → `out_valid=4'b0100` with lane 2=0xA5, then `4'b0001` with lane 0=0x3C; other lanes 0; 1-cycle latency.
- Packet lock: 3-beat packet 0x11/0x22/0x33 with sel=1 on beat 0 and sel changed to 3 on beats 1–2 → all three beats appear on lane 1; `out_last[1]` is set only on 0x33.
- Backpressure: `out_ready[1]=0` for 4 cycles with a beat held → `in_ready=0` and lane-1 data stable; release → one beat drains per cycle, no loss or duplication.
- Reset mid-packet: assert `rst` after beat 1 of a 3-beat packet → `out_valid=0`; the next beat with sel=3 routes to lane 3.
- Invalid select, N_CH=3, sel=3, 2-beat packet: with `STREAM_DEMUX_DROP_EN`, `drop_cnt` goes 0→2 and no `out_valid`; without it, both beats appear on lane 2.
